// File: rtl/exc_pkg.sv
// exc_pkg: shared exception-controller types, Exc_Vec bit positions and FSM encoding.
package exc_pkg;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'hBFC00380;
  localparam int V_PC_ADEL = 6;
  localparam int V_RI      = 5;
  localparam int V_OV      = 4;
  localparam int V_SYS     = 3;
  localparam int V_BRK     = 2;
  localparam int V_ADEL    = 1;
  localparam int V_ADES    = 0;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, REDIRECT = 2'd2} state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic        eret;
    logic [6:0]  flags;
  } stage_t;
endpackage

// File: rtl/exc_ctrl_if.sv
// exc_ctrl_if: pipeline-side and CP0-side signals of the exception controller.
interface exc_ctrl_if;
  logic        pipe_adv;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        if_adel;
  logic        id_ri;
  logic        id_syscall;
  logic        id_break;
  logic        id_eret;
  logic        id_bd;
  logic        ex_ov;
  logic        mem_adel;
  logic        mem_ades;
  logic [31:0] mem_addr;
  logic        ex_int_handle;
  logic [31:0] epc_value;
  logic [6:0]  Exc_Vec;
  logic        Exc_BD;
  logic [31:0] epc_in;
  logic [31:0] Exc_BadVaddr;
  logic        eret;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [15:0] exc_cnt;
  modport slave (
    input  pipe_adv, if_valid, if_pc, if_adel, id_ri, id_syscall, id_break, id_eret, id_bd,
           ex_ov, mem_adel, mem_ades, mem_addr, ex_int_handle, epc_value,
    output Exc_Vec, Exc_BD, epc_in, Exc_BadVaddr, eret, flush, pc_redirect, redirect_pc, exc_cnt
  );
  modport master (
    output pipe_adv, if_valid, if_pc, if_adel, id_ri, id_syscall, id_break, id_eret, id_bd,
           ex_ov, mem_adel, mem_ades, mem_addr, ex_int_handle, epc_value,
    input  Exc_Vec, Exc_BD, epc_in, Exc_BadVaddr, eret, flush, pc_redirect, redirect_pc, exc_cnt
  );
endinterface

// File: rtl/exc_stage_reg.sv
// exc_stage_reg: one shadow pipeline stage; clear drops only the valid bit.
module exc_stage_reg
  import exc_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en_i,
  input  logic   clr_i,
  input  stage_t d_i,
  output stage_t q_o
);
  stage_t stage_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) stage_q <= '0;
    else if (clr_i) stage_q.valid <= 1'b0;
    else if (en_i) stage_q <= d_i;
  assign q_o = stage_q;
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: tracks exception flags down ID/EX/MEM and sequences flush + PC redirect.
// Define EXC_CTRL_CNT_EN to build the committed-exception counter on exc_cnt.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);
  state_e      state_q;
  logic        flush_q, redir_q;
  logic [31:0] target_q;
  stage_t      id_d, ex_d, id_q, ex_q, mem_q;
  logic [6:0]  mem_flags;
  logic        run, go, clr, eret_w;
  assign run = state_q == RUN;
  assign id_d = '{valid: bus.if_valid, pc: bus.if_pc, bd: bus.id_bd, eret: bus.id_eret,
                  flags: {bus.if_adel, bus.id_ri, 1'b0, bus.id_syscall, bus.id_break, 2'b00}};
  always_comb begin
    ex_d = id_q;
    ex_d.flags[V_OV] = id_q.flags[V_OV] | bus.ex_ov;
  end
  exc_stage_reg u_id  (.clk(clk), .rst(rst), .en_i(bus.pipe_adv), .clr_i(clr), .d_i(id_d), .q_o(id_q));
  exc_stage_reg u_ex  (.clk(clk), .rst(rst), .en_i(bus.pipe_adv), .clr_i(clr), .d_i(ex_d), .q_o(ex_q));
  exc_stage_reg u_mem (.clk(clk), .rst(rst), .en_i(bus.pipe_adv), .clr_i(clr), .d_i(ex_q), .q_o(mem_q));
  assign mem_flags        = mem_q.flags | {5'b0, bus.mem_adel, bus.mem_ades};
  assign bus.Exc_Vec      = (mem_q.valid && run) ? mem_flags : 7'd0;
  assign bus.Exc_BD       = mem_q.bd;
  assign bus.epc_in       = mem_q.bd ? mem_q.pc - 32'd4 : mem_q.pc;
  assign bus.Exc_BadVaddr = mem_q.flags[V_PC_ADEL] ? mem_q.pc : bus.mem_addr;
  // any exception flag or a concurrent CP0 accept outranks eret
  assign eret_w = run && mem_q.valid && mem_q.eret && ~|mem_flags && !bus.ex_int_handle;
  assign go     = run && (bus.ex_int_handle || eret_w);
  assign clr    = !run || go;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      redir_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= go ? FLUSH : (state_q == FLUSH) ? REDIRECT : RUN;
      flush_q <= go;
      redir_q <= state_q == FLUSH;
      if (go) target_q <= bus.ex_int_handle ? EXC_ENTRY : bus.epc_value;
    end
  assign bus.eret        = eret_w;
  assign bus.flush       = flush_q;
  assign bus.pc_redirect = redir_q;
  assign bus.redirect_pc = target_q;
`ifdef EXC_CTRL_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else if (run && bus.ex_int_handle) cnt_q <= cnt_q + 16'd1;
  assign bus.exc_cnt = cnt_q;
`else
  assign bus.exc_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: vector table, corner sequences and randomized run against a pipeline model.
module tb_exc_ctrl;
  import exc_pkg::*;
  localparam logic [31:0] ENTRY = 32'hBFC00380;
  logic clk = 1'b0;
  logic rst = 1'b0;
  exc_ctrl_if bus();
  exc_ctrl #(.EXC_ENTRY(ENTRY)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int errs = 0;
  int checks = 0;
  typedef struct {
    logic [31:0] pc;
    logic adel, ri, sys, brk, er, bd, ov, madel, mades;
    logic [31:0] maddr;
    logic [6:0]  vec;
    logic [31:0] epc, bad;
    logic eret;
  } vec_t;
  vec_t tv[9];
  typedef struct {bit v; bit [31:0] pc; bit bd; bit er; bit [6:0] f;} ins_t;
  ins_t pipe[3];
  int phase;
  bit [31:0] tgt;
  bit [15:0] mcnt;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    bus.pipe_adv = 1; bus.if_valid = 0; bus.if_pc = 0; bus.if_adel = 0;
    bus.id_ri = 0; bus.id_syscall = 0; bus.id_break = 0; bus.id_eret = 0; bus.id_bd = 0;
    bus.ex_ov = 0; bus.mem_adel = 0; bus.mem_ades = 0; bus.mem_addr = 0;
    bus.ex_int_handle = 0; bus.epc_value = 0;
  endtask
  task automatic do_reset();
    rst = 0;
    clear_inputs();
    tick();
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
    phase = 0; tgt = 0; mcnt = 0;
  endtask
  task automatic inject(input vec_t t);
    bus.if_valid = 1; bus.if_pc = t.pc; bus.if_adel = t.adel; bus.id_ri = t.ri;
    bus.id_syscall = t.sys; bus.id_break = t.brk; bus.id_eret = t.er; bus.id_bd = t.bd;
    tick();
    bus.if_valid = 0; bus.if_adel = 0; bus.id_ri = 0; bus.id_syscall = 0;
    bus.id_break = 0; bus.id_eret = 0; bus.id_bd = 0; bus.ex_ov = t.ov;
    tick();
    bus.ex_ov = 0;
    tick();
  endtask
  function automatic logic [6:0] m_flags();
    return pipe[2].f | {5'b0, bus.mem_adel, bus.mem_ades};
  endfunction
  function automatic logic [6:0] m_vec();
    return (phase == 0 && pipe[2].v) ? m_flags() : 7'd0;
  endfunction
  function automatic logic m_eret();
    return phase == 0 && pipe[2].v && pipe[2].er && m_flags() == 0 && !bus.ex_int_handle;
  endfunction
  task automatic model_step();
    bit go;
    go = phase == 0 && (bus.ex_int_handle || m_eret());
    if (go) tgt = bus.ex_int_handle ? ENTRY : bus.epc_value;
`ifdef EXC_CTRL_CNT_EN
    if (phase == 0 && bus.ex_int_handle) mcnt = mcnt + 1;
`endif
    if (phase != 0 || go) begin
      for (int i = 0; i < 3; i++) pipe[i].v = 0;
    end else if (bus.pipe_adv) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[1].f[4] = pipe[1].f[4] | bus.ex_ov;
      pipe[0] = '{bus.if_valid, bus.if_pc, bus.id_bd, bus.id_eret,
                  {bus.if_adel, bus.id_ri, 1'b0, bus.id_syscall, bus.id_break, 2'b00}};
    end
    phase = go ? 1 : (phase == 1) ? 2 : 0;
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic trig;
    logic [31:0] texp;
    tv[0] = '{32'h1002, 1,0,0,0,0,0,0,0,0, 32'hDEAD, 7'h40, 32'h1002, 32'h1002, 0};
    tv[1] = '{32'h2004, 0,0,1,0,0,1,0,0,0, 32'h0,    7'h08, 32'h2000, 32'h0,    0};
    tv[2] = '{32'h2FF0, 0,0,0,0,1,0,0,0,0, 32'h44,   7'h00, 32'h2FF0, 32'h44,   1};
    tv[3] = '{32'h3100, 0,0,0,0,1,0,0,0,1, 32'h5557, 7'h01, 32'h3100, 32'h5557, 0};
    tv[4] = '{32'h0400, 0,1,0,0,0,1,0,0,0, 32'h8,    7'h20, 32'h03FC, 32'h8,    0};
    tv[5] = '{32'h0500, 0,0,0,1,0,0,1,0,0, 32'h9,    7'h14, 32'h0500, 32'h9,    0};
    tv[6] = '{32'h0600, 0,0,0,0,0,0,0,1,0, 32'h6001, 7'h02, 32'h0600, 32'h6001, 0};
    tv[7] = '{32'h0700, 0,0,0,0,0,0,0,0,0, 32'hA,    7'h00, 32'h0700, 32'hA,    0};
    tv[8] = '{32'h1006, 1,0,0,0,0,0,1,1,0, 32'hBEEF, 7'h52, 32'h1006, 32'h1006, 0};
    clear_inputs();
    tick();
    tick();
    chk("rst_flush", bus.flush, 0);
    chk("rst_redirect", bus.pc_redirect, 0);
    chk("rst_eret", bus.eret, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_vec", bus.Exc_Vec, 0);
    chk("rst_cnt", bus.exc_cnt, 0);
    for (int k = 0; k < 9; k++) begin
      do_reset();
      inject(tv[k]);
      bus.mem_adel = tv[k].madel; bus.mem_ades = tv[k].mades;
      bus.mem_addr = tv[k].maddr; bus.epc_value = 32'h3000;
      #1;
      chk($sformatf("tv%0d_vec", k), bus.Exc_Vec, tv[k].vec);
      chk($sformatf("tv%0d_epc", k), bus.epc_in, tv[k].epc);
      chk($sformatf("tv%0d_bd", k), bus.Exc_BD, tv[k].bd);
      chk($sformatf("tv%0d_bad", k), bus.Exc_BadVaddr, tv[k].bad);
      chk($sformatf("tv%0d_eret", k), bus.eret, tv[k].eret);
      trig = tv[k].vec != 0 || tv[k].eret;
      texp = tv[k].vec != 0 ? ENTRY : 32'h3000;
      bus.ex_int_handle = tv[k].vec != 0;
      #1;
      chk($sformatf("tv%0d_eret_h", k), bus.eret, tv[k].vec == 0 && tv[k].eret);
      tick();
      clear_inputs();
      chk($sformatf("tv%0d_flush", k), bus.flush, trig);
      chk($sformatf("tv%0d_redir0", k), bus.pc_redirect, 0);
      tick();
      chk($sformatf("tv%0d_redir1", k), bus.pc_redirect, trig);
      chk($sformatf("tv%0d_flush1", k), bus.flush, 0);
      if (trig) chk($sformatf("tv%0d_target", k), bus.redirect_pc, texp);
      tick();
      chk($sformatf("tv%0d_redir2", k), bus.pc_redirect, 0);
    end
    // exception held in MEM while stalled: flush must clear it
    do_reset();
    inject('{32'h7000, 0,0,0,1,0,0,0,0,0, 32'h0, 7'h00, 32'h0, 32'h0, 0});
    bus.pipe_adv = 0; bus.mem_ades = 1;
    #1;
    chk("stall_vec", bus.Exc_Vec, 7'h05);
    bus.ex_int_handle = 1;
    tick();
    bus.ex_int_handle = 0;
    chk("stall_flush", bus.flush, 1);
    chk("stall_vec_fl", bus.Exc_Vec, 0);
    tick();
    chk("stall_redir", bus.pc_redirect, 1);
    tick();
    chk("stall_vec_after", bus.Exc_Vec, 0);
    chk("stall_redir_off", bus.pc_redirect, 0);
    clear_inputs();
    // eret and CP0 accept in the same cycle
    do_reset();
    inject('{32'h8000, 0,0,0,0,1,0,0,0,0, 32'h0, 7'h00, 32'h0, 32'h0, 0});
    bus.epc_value = 32'h3000;
    #1;
    chk("same_eret", bus.eret, 1);
    bus.ex_int_handle = 1;
    #1;
    chk("same_eret_supp", bus.eret, 0);
    tick();
    bus.ex_int_handle = 0;
    chk("same_flush", bus.flush, 1);
    tick();
    chk("same_target", bus.redirect_pc, ENTRY);
    // inputs ignored during FLUSH/REDIRECT
    do_reset();
    inject('{32'h9000, 0,0,0,0,1,0,0,0,0, 32'h0, 7'h00, 32'h0, 32'h0, 0});
    bus.epc_value = 32'h3000;
    tick();
    bus.ex_int_handle = 1; bus.if_valid = 1; bus.id_syscall = 1; bus.epc_value = 32'h4444;
    chk("ign_flush", bus.flush, 1);
    tick();
    bus.ex_int_handle = 0;
    chk("ign_redir", bus.pc_redirect, 1);
    chk("ign_target", bus.redirect_pc, 32'h3000);
    tick();
    clear_inputs();
    chk("ign_flush_off", bus.flush, 0);
    chk("ign_cnt", bus.exc_cnt, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("ign_vec", bus.Exc_Vec, 0);
    // reset abandons a pending redirect
    do_reset();
    inject('{32'hA000, 0,1,0,0,0,0,0,0,0, 32'h0, 7'h00, 32'h0, 32'h0, 0});
    bus.ex_int_handle = 1;
    tick();
    bus.ex_int_handle = 0;
    tick();
    chk("rr_redir", bus.pc_redirect, 1);
    rst = 0;
    #1;
    chk("rr_redir_rst", bus.pc_redirect, 0);
    chk("rr_target_rst", bus.redirect_pc, 0);
    tick();
    rst = 1;
    tick();
    chk("rr_redir_after", bus.pc_redirect, 0);
    chk("rr_flush_after", bus.flush, 0);
    // randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.pipe_adv = ($urandom % 4) != 0;
      bus.if_valid = $urandom % 2;
      bus.if_pc = $urandom;
      bus.if_adel = ($urandom % 8) == 0;
      bus.id_ri = ($urandom % 16) == 0;
      bus.id_syscall = ($urandom % 16) == 0;
      bus.id_break = ($urandom % 16) == 0;
      bus.id_eret = ($urandom % 6) == 0;
      bus.id_bd = ($urandom % 4) == 0;
      bus.ex_ov = ($urandom % 16) == 0;
      bus.mem_adel = ($urandom % 16) == 0;
      bus.mem_ades = ($urandom % 16) == 0;
      bus.mem_addr = $urandom;
      bus.epc_value = $urandom;
      bus.ex_int_handle = (m_vec() != 0 && ($urandom % 2) == 1) || ($urandom % 32) == 0;
      #1;
      chk("rnd_vec", bus.Exc_Vec, m_vec());
      chk("rnd_eret", bus.eret, m_eret());
      chk("rnd_flush", bus.flush, phase == 1);
      chk("rnd_redir", bus.pc_redirect, phase == 2);
      chk("rnd_target", bus.redirect_pc, tgt);
      chk("rnd_cnt", bus.exc_cnt, mcnt);
      if (pipe[2].v) begin
        chk("rnd_epc", bus.epc_in, pipe[2].bd ? pipe[2].pc - 4 : pipe[2].pc);
        chk("rnd_bd", bus.Exc_BD, pipe[2].bd);
        chk("rnd_bad", bus.Exc_BadVaddr, pipe[2].f[6] ? pipe[2].pc : bus.mem_addr);
      end
      model_step();
      tick();
    end
    clear_inputs();
`ifdef EXC_CTRL_CNT_EN
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      bus.ex_int_handle = 1;
      tick();
      bus.ex_int_handle = 0;
      tick();
      tick();
    end
    chk("cnt_wrap", bus.exc_cnt, 0);
    bus.ex_int_handle = 1;
    tick();
    bus.ex_int_handle = 0;
    chk("cnt_after_wrap", bus.exc_cnt, 1);
`else
    chk("cnt_absent", bus.exc_cnt, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
